// File: rtl/div_radix2_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// FSM state codes, handshake levels and the zero word used by the EX stage.
package div_radix2_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_START          = 1'b1;
  localparam logic DIV_STOP           = 1'b0;
  localparam logic RESULT_READY       = 1'b1;
  localparam logic RESULT_NOT_READY   = 1'b0;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

endpackage

// File: rtl/div_radix2.sv
// Multi-cycle DIV/DIVU unit: restoring shift-subtract, one quotient bit per cycle.
// Result packs {remainder, quotient}; valid only while ready_o is high.
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  div_state_e           r_state,   w_state_nxt;
  logic [CW-1:0]        r_cnt,     w_cnt_nxt;
  logic [WIDTH-1:0]     r_rem,     w_rem_nxt;
  logic [WIDTH-1:0]     r_quo,     w_quo_nxt;
  logic [WIDTH-1:0]     r_divisor, w_divisor_nxt;
  logic                 r_signed,  w_signed_nxt;
  logic                 r_neg1,    w_neg1_nxt;
  logic                 r_neg2,    w_neg2_nxt;
  logic                 r_ready,   w_ready_nxt;
  logic [2*WIDTH-1:0]   r_result,  w_result_nxt;

  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_mag1, w_mag2;
  logic [WIDTH-1:0]     w_quo_fix, w_rem_fix;

  // The quotient register starts out holding the dividend, so shifting {rem, quo}
  // feeds the dividend MSB into the remainder LSB. Because rem < divisor always holds,
  // a set top bit in the 33-bit difference means the trial subtraction failed.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};

  assign w_mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  assign w_quo_fix = (r_signed && (r_neg1 ^ r_neg2)) ? -r_quo : r_quo;
  assign w_rem_fix = (r_signed && r_neg1)            ? -r_rem : r_rem;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_ready   <= RESULT_NOT_READY;
      r_result  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rem     <= w_rem_nxt;
      r_quo     <= w_quo_nxt;
      r_divisor <= w_divisor_nxt;
      r_signed  <= w_signed_nxt;
      r_neg1    <= w_neg1_nxt;
      r_neg2    <= w_neg2_nxt;
      r_ready   <= w_ready_nxt;
      r_result  <= w_result_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rem_nxt     = r_rem;
    w_quo_nxt     = r_quo;
    w_divisor_nxt = r_divisor;
    w_signed_nxt  = r_signed;
    w_neg1_nxt    = r_neg1;
    w_neg2_nxt    = r_neg2;
    w_ready_nxt   = r_ready;
    w_result_nxt  = r_result;

    unique case (r_state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DIV_BYZERO;
          end else begin
            w_state_nxt   = DIV_ON;
            w_cnt_nxt     = '0;
            w_rem_nxt     = '0;
            w_quo_nxt     = w_mag1;
            w_divisor_nxt = w_mag2;
            w_signed_nxt  = signed_div_i;
            w_neg1_nxt    = opdata1_i[WIDTH-1];
            w_neg2_nxt    = opdata2_i[WIDTH-1];
          end
        end
      end

      DIV_BYZERO: begin
        w_state_nxt  = DIV_END;
        w_result_nxt = '0;
        w_ready_nxt  = RESULT_READY;
      end

      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt = DIV_FREE;
          w_cnt_nxt   = '0;
          w_ready_nxt = RESULT_NOT_READY;
        end else if (r_cnt != LAST_CNT) begin
          w_rem_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
          w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_state_nxt  = DIV_END;
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = RESULT_READY;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = RESULT_NOT_READY;
          w_result_nxt = '0;
        end
      end

      default: w_state_nxt = DIV_FREE;
    endcase
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: timeline model plus directed literal vectors.
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  div_radix2 #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference division from plain arithmetic; results as {remainder, quotient}.
  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Timeline model: an accepted request completes a fixed number of edges later.
  bit          m_busy, m_byzero, m_ready;
  logic [63:0] m_res, m_pending;
  int          m_edge, m_done_at;

  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      m_busy  = 1'b0;
      m_ready = 1'b0;
      m_res   = 64'h0;
    end else if (m_ready) begin
      if (!start_i) begin
        m_ready = 1'b0;
        m_res   = 64'h0;
      end
    end else if (m_busy) begin
      if (annul_i && !m_byzero) begin
        m_busy = 1'b0;
      end else if (m_edge == m_done_at) begin
        m_busy  = 1'b0;
        m_ready = 1'b1;
        m_res   = m_pending;
      end
    end else if (start_i && !annul_i) begin
      m_busy    = 1'b1;
      m_byzero  = (opdata2_i == 32'h0);
      m_pending = div_model(signed_div_i, opdata1_i, opdata2_i);
      m_done_at = m_edge + (m_byzero ? 1 : 33);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ready",  {63'h0, ready_o}, {63'h0, m_ready});
      check("model_result", result_o, m_ready ? m_res : 64'h0);
    end
  end

  // Starts an op and waits for ready_o; returns the edge count with acceptance as edge 1.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit toggle, output int edges);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    edges = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (ready_o) break;
      if (toggle) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~signed_div_i;
      end
    end
    if (!ready_o) check("ready_timeout", 64'h0, 64'h1);
  endtask

  task automatic release_start();
    start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("drop_ready",  {63'h0, ready_o}, 64'h0);
    check("drop_result", result_o, 64'h0);
  endtask

  task automatic partial_op(input logic [31:0] a, input logic [31:0] b, input int n);
    signed_div_i = 1'b0; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  int edges;
  int rises;

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    @(posedge clk); @(negedge clk);
    chk_en = 1'b1;
    check("reset_ready",  {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    run_op(1'b0, 32'd100, 32'd7, 1'b0, edges);
    check("u100_7_lat", 64'(edges), 64'd34);
    check("u100_7_res", result_o, 64'h00000002_0000000E);
    release_start();

    run_op(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0, edges);
    check("s_m7_2_res", result_o, 64'hFFFFFFFF_FFFFFFFD);
    release_start();

    run_op(1'b0, 32'hFFFF_FFF9, 32'h2, 1'b0, edges);
    check("u_fff9_2_res", result_o, 64'h00000001_7FFFFFFC);
    release_start();

    run_op(1'b0, 32'd5, 32'd0, 1'b0, edges);
    check("byzero_lat", 64'(edges), 64'd2);
    check("byzero_res", result_o, 64'h0);
    release_start();

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, edges);
    check("ovf_lat", 64'(edges), 64'd34);
    check("ovf_res", result_o, 64'h00000000_80000000);
    release_start();

    // Annul sampled on edge 11; ready must never rise afterwards.
    partial_op(32'd50, 32'd5, 10);
    annul_i = 1'b1;
    @(posedge clk); @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    rises = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (ready_o) rises++;
    end
    check("annul_no_ready", 64'(rises), 64'd0);

    run_op(1'b0, 32'd9, 32'd3, 1'b0, edges);
    check("u9_3_lat", 64'(edges), 64'd34);
    check("u9_3_res", result_o, 64'h00000000_00000003);
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      check("end_hold_ready", {63'h0, ready_o}, 64'h1);
      check("end_hold_res",   result_o, 64'h00000000_00000003);
    end
    release_start();

    run_op(1'b0, 32'd1000, 32'd10, 1'b1, edges);
    check("toggle_lat", 64'(edges), 64'd34);
    check("toggle_res", result_o, 64'h00000000_00000064);
    release_start();

    // Reset sampled on edge 20 of an op in flight.
    partial_op(32'd123456, 32'd789, 19);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_ready",  {63'h0, ready_o}, 64'h0);
    check("midrst_result", result_o, 64'h0);
    rst = 1'b0; start_i = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end

    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, edges);
    check("u_max_1_lat", 64'(edges), 64'd34);
    check("u_max_1_res", result_o, 64'h00000000_FFFFFFFF);
    release_start();

    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, edges);
    check("s_7_m2_res", result_o, 64'h00000001_FFFFFFFD);
    release_start();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
Name: div_radix2

Overview:
Multi-cycle 32-bit integer divider for the EX stage. It handles DIV and DIVU with a restoring shift-subtract algorithm, one quotient bit per cycle. It is the responder side of EX's start/ready handshake: EX raises start and stalls the pipeline until ready, then drops start. The result packs the remainder in [63:32] (written to HI) and the quotient in [31:0] (written to LO).

Parameters:
WIDTH, 32, operand width; the result is 2*WIDTH and the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
opdata1_i  input  32  dividend; sampled with start
opdata2_i  input  32  divisor; sampled with start
start_i  input  1  request; held high by EX until ready_o is seen
annul_i  input  1  abort the in-flight divide
result_o  output  64  {remainder, quotient}; valid only while ready_o=1, otherwise 0
ready_o  output  1  result valid (DivResultReady)

Behaviour:
- Reset
  - rst=1 at a rising edge forces state=FREE, cnt=0, ready_o=0, result_o=0.
  - Reset has priority over everything, including an operation in progress.
- FSM states: FREE, BYZERO, ON, END. All outputs are registered.
- FREE
  - Leaves FREE only when start_i=1 and annul_i=0.
  - If opdata2_i==0, go to BYZERO.
  - Otherwise latch the operands and go to ON with cnt=0.
  - Operand latch: if signed_div_i=1 and an operand is negative, latch its two's-complement magnitude. Also latch signed_div_i and both operand sign bits.
- BYZERO
  - Next edge goes to END with result 0.
  - ready_o becomes 1 after the 2nd edge, counting the start-sampling edge as edge 1.
- ON
  - Keep partial remainder r (33 b) and quotient q (32 b).
  - Each edge while cnt<32:
    - shift {r,q} left 1, with the dividend MSB entering r[0];
    - compute d = r - divisor;
    - if d >= 0: r=d and q[0]=1, else q[0]=0;
    - cnt++.
  - At cnt==32, apply the sign fixup and go to END:
    - quotient is negated if signed and the operand signs differ;
    - remainder is negated if signed and the dividend is negative.
  - ready_o becomes 1 after edge 34, counting the start-sampling edge as edge 1.
  - annul_i=1 in ON: go to FREE on the next edge, with cnt=0 and ready_o kept 0.
- END
  - ready_o=1 and result_o is held.
  - While start_i stays 1, remain in END and hold the result.
  - When start_i=0, go to FREE on the next edge and clear ready_o and result_o to 0.
  - annul_i is ignored in END.
- Arithmetic rules
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wrap, no trap).
  - Sign of the remainder equals the sign of the dividend.
- Changes to operand inputs after start is accepted have no effect.
- start_i rising while in ON is ignored; start_i is only sampled in FREE.

Decomposition:
- Shared defines header (lib/defines.vh) holds:
  - state codes DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11;
  - DivStart=1'b1, DivStop=1'b0;
  - DivResultReady=1'b1, DivResultNotReady=1'b0;
  - ZeroWord.
- No sub-module. The subtract/compare is a single 33-bit expression inside the block.

Test Plan:
- Unsigned 100/7: start held → ready_o at edge 34; result_o=0x00000002_0000000E. Drop start → ready_o=0 and result_o=0 after the next edge.
- Signed −7/2 (0xFFFFFFF9, 0x2) → result_o=0xFFFFFFFF_FFFFFFFD. The same operands unsigned → quotient 0x7FFFFFFC, remainder 0x1.
- Divide by zero: 5/0 → ready_o at edge 2, result_o=0. Signed 0x80000000/0xFFFFFFFF → 0x00000000_80000000 at edge 34.
- Annul in ON: annul_i pulsed at edge 10 → FREE at edge 11; ready_o never rises. A new start of 9/3 then gives {0, 3} at edge 34 of the new op.
- Start held in END for 5 cycles → ready_o and result_o stable throughout. Operand inputs toggled during ON → result is unchanged.
- rst asserted at edge 20 of an op → after the next edge ready_o=0, result_o=0, state FREE. After rst drops, a fresh 0xFFFFFFFF/1 unsigned → {0, 0xFFFFFFFF}.
